// File: rtl/seg_dec_pkg.sv
// rtl/seg_dec_pkg.sv - segment patterns, ASCII codes, checker states and the pattern decoder
package seg_dec_pkg;

    // Active-high {A,B,C,D,E,F,G}
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_H     = 7'b0110111;
    localparam logic [6:0] SEG_L     = 7'b0001110;

    localparam logic [7:0] ASCII_H       = 8'h48;
    localparam logic [7:0] ASCII_E       = 8'h45;
    localparam logic [7:0] ASCII_L       = 8'h4C;
    localparam logic [7:0] ASCII_O       = 8'h4F;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_BLANK   = 8'h00;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    localparam int CHK_STATE_W = 3;
    typedef logic [CHK_STATE_W-1:0] chk_state_t;
    localparam chk_state_t EXP_H     = 3'd0;
    localparam chk_state_t EXP_E     = 3'd1;
    localparam chk_state_t EXP_L     = 3'd2;
    localparam chk_state_t EXP_O     = 3'd3;
    localparam chk_state_t EXP_BLANK = 3'd4;

    typedef struct packed {
        logic       known;
        logic [7:0] code;
    } seg_char_t;

    function automatic seg_char_t seg_decode(input logic [6:0] pat, input logic [7:0] zero_char);
        seg_char_t r;
        r.known = 1'b1;
        r.code  = ASCII_UNKNOWN;
        case (pat)
            SEG_BLANK: r.code = ASCII_BLANK;
            SEG_0:     r.code = zero_char;
            SEG_1:     r.code = 8'h31;
            SEG_2:     r.code = 8'h32;
            SEG_3:     r.code = 8'h33;
            SEG_4:     r.code = 8'h34;
            SEG_5:     r.code = 8'h35;
            SEG_6:     r.code = 8'h36;
            SEG_7:     r.code = 8'h37;
            SEG_8:     r.code = 8'h38;
            SEG_9:     r.code = 8'h39;
            SEG_A:     r.code = 8'h41;
            SEG_B:     r.code = 8'h42;
            SEG_C:     r.code = 8'h43;
            SEG_D:     r.code = 8'h44;
            SEG_E:     r.code = ASCII_E;
            SEG_F:     r.code = 8'h46;
            SEG_H:     r.code = ASCII_H;
            SEG_L:     r.code = ASCII_L;
            default:   r.known = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/segment_to_char_decoder_if.sv
// rtl/segment_to_char_decoder_if.sv - segment lines toward the display and recovered-character outputs
interface segment_to_char_decoder_if;
    logic       i_Segment_A;
    logic       i_Segment_B;
    logic       i_Segment_C;
    logic       i_Segment_D;
    logic       i_Segment_E;
    logic       i_Segment_F;
    logic       i_Segment_G;
    logic [7:0] o_Char;
    logic       o_Valid;
    logic       o_Unknown;
    logic       o_Seq_Done;
    logic       o_Seq_Err;

    modport master (
        output i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
               i_Segment_E, i_Segment_F, i_Segment_G,
        input  o_Char, o_Valid, o_Unknown, o_Seq_Done, o_Seq_Err
    );

    modport slave (
        input  i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
               i_Segment_E, i_Segment_F, i_Segment_G,
        output o_Char, o_Valid, o_Unknown, o_Seq_Done, o_Seq_Err
    );
endinterface

// File: rtl/seg_hello_checker.sv
// rtl/seg_hello_checker.sv - HELLO sequence checker on decoded characters, built only with SEG_DEC_HELLO_CHECK_EN
module seg_hello_checker
    import seg_dec_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Valid,
    input  logic [7:0] i_Char,
    output logic       o_Seq_Done,
    output logic       o_Seq_Err
);

`ifdef SEG_DEC_HELLO_CHECK_EN
    chk_state_t state;
    chk_state_t state_nxt;
    logic       hit;
    logic       done_nxt;
    logic       err_nxt;

    always_comb begin
        case (state)
            EXP_H:     hit = (i_Char == ASCII_H);
            EXP_E:     hit = (i_Char == ASCII_E);
            EXP_L:     hit = (i_Char == ASCII_L);
            EXP_O:     hit = (i_Char == ASCII_O) || (i_Char == ASCII_ZERO);
            EXP_BLANK: hit = (i_Char == ASCII_BLANK);
            default:   hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (state > EXP_BLANK) begin
            state_nxt = EXP_H;
        end else if (i_Valid) begin
            if (hit) begin
                done_nxt  = (state == EXP_BLANK);
                state_nxt = (state == EXP_BLANK) ? EXP_H : state + chk_state_t'(1);
            end else if (!(state == EXP_H && i_Char == ASCII_BLANK)) begin
                // A stray 'H' already starts the next word
                err_nxt   = 1'b1;
                state_nxt = (i_Char == ASCII_H) ? EXP_E : EXP_H;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= EXP_H;
            o_Seq_Done <= 1'b0;
            o_Seq_Err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_Seq_Done <= done_nxt;
            o_Seq_Err  <= err_nxt;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = &{i_Clk, i_Rst_L, i_Valid, i_Char};
    assign o_Seq_Done    = 1'b0;
    assign o_Seq_Err     = 1'b0;
`endif

endmodule

// File: rtl/segment_to_char_decoder.sv
// rtl/segment_to_char_decoder.sv - resync, deglitch and decode the 7-segment bus to ASCII; SEG_DEC_HELLO_CHECK_EN adds the sequence checker
module segment_to_char_decoder
    import seg_dec_pkg::*;
#(
    parameter int         STABLE_CYCLES = 16,
    parameter bit         ACTIVE_LOW    = 1'b1,
    parameter logic [7:0] ZERO_CHAR     = 8'h4F
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    segment_to_char_decoder_if.slave  bus
);

    localparam int             CNT_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]     IDLE_PINS = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0]       pins;
    logic [6:0]       sync1;
    logic [6:0]       sync2;
    logic [6:0]       pattern;
    logic [6:0]       candidate;
    logic [6:0]       committed;
    logic [CNT_W-1:0] count;
    logic             commit;
    seg_char_t        dec;
    logic [7:0]       char_q;
    logic             valid_q;
    logic             unknown_q;
    logic             seq_done;
    logic             seq_err;

    assign pins = {bus.i_Segment_A, bus.i_Segment_B, bus.i_Segment_C, bus.i_Segment_D,
                   bus.i_Segment_E, bus.i_Segment_F, bus.i_Segment_G};

    // Resets to the idle pin level so a blank display looks unchanged across reset
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1 <= IDLE_PINS;
            sync2 <= IDLE_PINS;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign pattern = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            candidate <= 7'b0;
            count     <= '0;
        end else if (pattern != candidate) begin
            candidate <= pattern;
            count     <= '0;
        end else if (count != CNT_MAX) begin
            count     <= count + CNT_W'(1);
        end
    end

    assign commit = (count == CNT_MAX) && (candidate != committed);
    assign dec    = seg_decode(candidate, ZERO_CHAR);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            committed <= 7'b0;
            char_q    <= 8'h00;
            valid_q   <= 1'b0;
            unknown_q <= 1'b0;
        end else begin
            valid_q <= commit;
            if (commit) begin
                committed <= candidate;
                char_q    <= dec.code;
                unknown_q <= ~dec.known;
            end
        end
    end

    seg_hello_checker u_checker (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Valid    (valid_q),
        .i_Char     (char_q),
        .o_Seq_Done (seq_done),
        .o_Seq_Err  (seq_err)
    );

    assign bus.o_Char     = char_q;
    assign bus.o_Valid    = valid_q;
    assign bus.o_Unknown  = unknown_q;
    assign bus.o_Seq_Done = seq_done;
    assign bus.o_Seq_Err  = seq_err;

endmodule

// File: tb/tb_segment_to_char_decoder.sv
// tb/tb_segment_to_char_decoder.sv - randomized and directed bench with a sliding-window reference model
module tb_segment_to_char_decoder;

    localparam int S = 16;
`ifdef SEG_DEC_HELLO_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [6:0] P_BLANK = 7'b0000000;
    localparam logic [6:0] P_H     = 7'b0110111;
    localparam logic [6:0] P_E     = 7'b1001111;
    localparam logic [6:0] P_L     = 7'b0001110;
    localparam logic [6:0] P_O     = 7'b1111110;
    localparam logic [6:0] P_A     = 7'b1110111;
    localparam logic [6:0] P_1     = 7'b0110000;
    localparam logic [6:0] P_BAD   = 7'b1010101;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [6:0] pins_ah = 7'b0;
    always #5 clk = ~clk;

    segment_to_char_decoder_if sif();
    assign {sif.i_Segment_A, sif.i_Segment_B, sif.i_Segment_C, sif.i_Segment_D,
            sif.i_Segment_E, sif.i_Segment_F, sif.i_Segment_G} = ~pins_ah;

    segment_to_char_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1), .ZERO_CHAR(8'h4F)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (sif)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [6:0] tbl_pat [19] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                                 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1111110,
                                 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
                                 7'b1000111, 7'b0110111, 7'b0001110, 7'b0000000};
    logic [7:0] tbl_chr [19] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                 8'h4F, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h48, 8'h4C, 8'h00};

    // Reference: a pattern commits once the last S pin samples (ending 3 edges back) agree and differ from the last commit
    logic [6:0] hist[$];
    logic [6:0] m_committed;
    bit         exp_valid, exp_unk, exp_done, exp_err, ev_pending;
    logic [7:0] exp_char, ev_char;
    int         seq_idx;
    int         ev_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] ev_q[$];

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < S + 3; i++) hist.push_back(7'b0);
        m_committed = 7'b0;
        exp_valid = 0; exp_done = 0; exp_err = 0; ev_pending = 0;
        seq_idx = 0;
    endfunction

    function automatic void ref_decode(input logic [6:0] p, output logic [7:0] c, output bit unk);
        c = 8'h3F;
        unk = 1;
        for (int i = 0; i < 19; i++)
            if (tbl_pat[i] == p) begin
                c = tbl_chr[i];
                unk = 0;
            end
    endfunction

    function automatic void seq_step(input logic [7:0] c);
        bit hit;
        case (seq_idx)
            0: hit = (c == 8'h48);
            1: hit = (c == 8'h45);
            2: hit = (c == 8'h4C);
            3: hit = (c == 8'h4F) || (c == 8'h30);
            default: hit = (c == 8'h00);
        endcase
        if (hit) begin
            if (seq_idx == 4) begin
                exp_done = 1;
                seq_idx = 0;
            end else begin
                seq_idx++;
            end
        end else if (!(seq_idx == 0 && c == 8'h00)) begin
            exp_err = 1;
            seq_idx = (c == 8'h48) ? 1 : 0;
        end
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int  last;
            bit  stable;
            exp_done = 0;
            exp_err  = 0;
            if (CHK_EN && ev_pending) seq_step(ev_char);
            ev_pending = 0;
            hist.push_back(pins_ah);
            last = hist.size() - 1;
            stable = 1;
            for (int i = last - S - 2; i <= last - 3; i++)
                if (hist[i] != hist[last - 3]) stable = 0;
            exp_valid = stable && (hist[last - 3] != m_committed);
            if (exp_valid) begin
                ref_decode(hist[last - 3], exp_char, exp_unk);
                m_committed = hist[last - 3];
                ev_pending = 1;
                ev_char = exp_char;
            end
            void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", sif.o_Valid, exp_valid);
            if (exp_valid) begin
                chk("char", sif.o_Char, exp_char);
                chk("unknown", sif.o_Unknown, exp_unk);
            end
            chk("seq_done", sif.o_Seq_Done, exp_done);
            chk("seq_err", sif.o_Seq_Err, exp_err);
            if (sif.o_Valid) begin
                ev_cnt++;
                ev_q.push_back(sif.o_Char);
            end
            if (sif.o_Seq_Done) done_cnt++;
            if (sif.o_Seq_Err) err_cnt++;
        end
    end

    task automatic hold(input logic [6:0] p, input int n);
        pins_ah = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_char"}, sif.o_Char, 8'h00);
        chk({tag, "_valid"}, sif.o_Valid, 1'b0);
        chk({tag, "_unknown"}, sif.o_Unknown, 1'b0);
        chk({tag, "_done"}, sif.o_Seq_Done, 1'b0);
        chk({tag, "_err"}, sif.o_Seq_Err, 1'b0);
    endtask

    task automatic pulse_reset();
        pins_ah = P_BLANK;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_seq [5] = '{8'h48, 8'h45, 8'h4C, 8'h4F, 8'h00};

    initial begin
        int lat, base, ev0, d0, e0;

        pins_ah = P_BLANK;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Blank display out of reset never produces an event
        hold(P_BLANK, 100);
        chk("blank_events", ev_cnt, 0);
        chk("blank_char", sif.o_Char, 8'h00);

        pins_ah = P_H;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (sif.o_Valid) begin
                lat = k;
                break;
            end
        end
        chk("h_latency", lat, S + 3);
        chk("h_char", sif.o_Char, 8'h48);
        chk("h_unknown", sif.o_Unknown, 1'b0);
        @(negedge clk);
        hold(P_H, 10);

        ev0 = ev_cnt;
        hold(P_E, 30);
        hold(P_L, 5);
        hold(P_E, 30);
        chk("glitch_events", ev_cnt - ev0, 1);
        chk("glitch_char", sif.o_Char, 8'h45);

        pulse_reset();
        hold(P_BLANK, 10);
        base = ev_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        hold(P_H, 30);
        hold(P_E, 30);
        hold(P_L, 60);
        hold(P_O, 30);
        hold(P_BLANK, 30);
        chk("hello_events", ev_q.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < ev_q.size()) chk("hello_seq", ev_q[base + i], exp_seq[i]);
        chk("hello_done", done_cnt - d0, CHK_EN ? 1 : 0);
        chk("hello_err", err_cnt - e0, 0);

        e0 = err_cnt;
        hold(P_H, 30);
        hold(P_E, 30);
        hold(P_A, 30);
        chk("a_char", sif.o_Char, 8'h41);
        chk("a_err", err_cnt - e0, CHK_EN ? 1 : 0);
        d0 = done_cnt;
        e0 = err_cnt;
        hold(P_H, 30);
        hold(P_E, 30);
        hold(P_L, 30);
        hold(P_O, 30);
        hold(P_BLANK, 30);
        chk("rearm_done", done_cnt - d0, CHK_EN ? 1 : 0);
        chk("rearm_err", err_cnt - e0, 0);

        hold(P_BAD, 30);
        chk("bad_char", sif.o_Char, 8'h3F);
        chk("bad_unknown", sif.o_Unknown, 1'b1);
        hold(P_1, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        hold(P_1, 30);
        chk("post_rst_char", sif.o_Char, 8'h31);

        for (int it = 0; it < 120; it++) begin
            logic [6:0] p;
            if ($urandom_range(0, 9) < 7) p = tbl_pat[$urandom_range(0, 18)];
            else p = 7'($urandom());
            hold(p, $urandom_range(1, 2 * S + 4));
        end
        hold(P_BLANK, S + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
